voq_sched_ctrl: RTL and testbench

Virtual-output-queue bookkeeping and sequencing controller for the pSLIP crossbar scheduler. Tracks per-(input, output) cell occupancy from arrival strobes and converts it into the priority request matrix. Launches a scheduler epoch, waits for the decision, validates it, and then issues the crossbar configuration and per-input dequeue commands. Sits between the ingress VOQ buffers and `pri_scheduler`.

---
 rtl/voq_sched_ctrl.sv | 175 +++++++++++++++++
 tb/tb_voq_sched_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voq_sched_ctrl.sv
// VOQ occupancy tracker and pSLIP epoch sequencer: snapshots request
// priorities, waits for a match, validates it, then drives xbar and dequeues.
module voq_sched_ctrl #(
  parameter int N   = 4,
  parameter int P   = 64,
  parameter int D   = 255,
  parameter int TMO = 256,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int PW = $clog2(P),
  localparam int CW = $clog2(D + 1),
  localparam int TW = (TMO > 1) ? $clog2(TMO) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N-1:0]                arr_valid,
  input  logic [N-1:0][AW-1:0]        arr_dst,
  output logic [0:N-1][0:N-1][PW-1:0] pri_req_out,
  output logic                        start,
  input  logic [N-1:0][N-1:0]         decision,
  input  logic                        decision_ready,
  output logic [N-1:0][N-1:0]         xbar_cfg,
  output logic                        xbar_valid,
  output logic [N-1:0]                deq_valid,
  output logic [N-1:0][AW-1:0]        deq_dst,
  output logic [N-1:0]                overflow,
  output logic                        sched_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_APPLY
  } state_t;

  state_t                        state_q;
  logic [N-1:0][N-1:0][CW-1:0]   occ_q, occ_d;
  logic [N-1:0]                  ovf_q, ovf_d;
  logic [0:N-1][0:N-1][PW-1:0]   pri_q, pri_c;
  logic                          start_q;
  logic [TW-1:0]                 tmo_q;
  logic [N-1:0][N-1:0]           cfg_q;
  logic                          xv_q;
  logic [N-1:0]                  dv_q;
  logic [N-1:0][AW-1:0]          dd_q;
  logic                          err_q;

  logic                          any_occ;
  logic                          dec_ok;
  logic [N-1:0]                  row_hit;
  logic [N-1:0][AW-1:0]          row_dst;
  logic [N-1:0]                  col;

  // Dequeue strobes are live in APPLY, so the decrement lands at its end.
  always_comb begin
    occ_d = occ_q;
    ovf_d = ovf_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (arr_valid[i] && arr_dst[i] == AW'(j)) begin
          if (!(dv_q[i] && dd_q[i] == AW'(j))) begin
            if (occ_q[i][j] == CW'(D)) ovf_d[i] = 1'b1;
            else occ_d[i][j] = occ_q[i][j] + 1'b1;
          end
        end else if (dv_q[i] && dd_q[i] == AW'(j)) begin
          occ_d[i][j] = occ_q[i][j] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    any_occ = 1'b0;
    pri_c   = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (occ_q[i][j] != '0) any_occ = 1'b1;
        pri_c[i][j] = (int'(occ_q[i][j]) > P - 1) ?
                      PW'(P - 1) : PW'(occ_q[i][j]);
      end
    end
  end

  // A match is legal when it is a partial permutation over requested pairs.
  always_comb begin
    dec_ok  = 1'b1;
    row_hit = '0;
    row_dst = '0;
    col     = '0;
    for (int i = 0; i < N; i++) begin
      if ($countones(decision[i]) > 1) dec_ok = 1'b0;
      row_hit[i] = |decision[i];
      for (int j = 0; j < N; j++) begin
        if (decision[i][j]) begin
          row_dst[i] = AW'(j);
          if (pri_q[i][j] == '0) dec_ok = 1'b0;
        end
      end
    end
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) col[i] = decision[i][j];
      if ($countones(col) > 1) dec_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      occ_q   <= '0;
      ovf_q   <= '0;
      pri_q   <= '0;
      start_q <= 1'b0;
      tmo_q   <= '0;
      cfg_q   <= '0;
      xv_q    <= 1'b0;
      dv_q    <= '0;
      dd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
      xv_q  <= 1'b0;
      dv_q  <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (any_occ) begin
            state_q <= S_LAUNCH;
            start_q <= 1'b1;
            pri_q   <= pri_c;
          end
        end
        S_LAUNCH: begin
          state_q <= S_WAIT;
          tmo_q   <= '0;
        end
        S_WAIT: begin
          if (decision_ready) begin
            state_q <= S_APPLY;
            start_q <= 1'b0;
            tmo_q   <= '0;
            if (dec_ok) begin
              xv_q  <= 1'b1;
              cfg_q <= decision;
              dv_q  <= row_hit;
              dd_q  <= row_dst;
            end else begin
              err_q <= 1'b1;
            end
          end else if (tmo_q == TW'(TMO - 1)) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            tmo_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_APPLY: begin
          state_q <= S_IDLE;
          dd_q    <= '0;
        end
      endcase
    end
  end

  assign pri_req_out = pri_q;
  assign start       = start_q;
  assign xbar_cfg    = cfg_q;
  assign xbar_valid  = xv_q;
  assign deq_valid   = dv_q;
  assign deq_dst     = dd_q;
  assign overflow    = ovf_q;
  assign sched_err   = err_q;

endmodule

// File: tb/tb_voq_sched_ctrl.sv
// Bench for voq_sched_ctrl: directed epochs plus random traffic,
// checked every cycle against an integer-level model of the controller.
module tb_voq_sched_ctrl;

  localparam int N   = 4;
  localparam int P   = 64;
  localparam int D   = 255;
  localparam int TMO = 256;
  localparam int AW  = 2;
  localparam int PW  = 6;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [N-1:0]                arr_valid;
  logic [N-1:0][AW-1:0]        arr_dst;
  logic [0:N-1][0:N-1][PW-1:0] pri_req_out;
  logic                        start;
  logic [N-1:0][N-1:0]         decision;
  logic                        decision_ready;
  logic [N-1:0][N-1:0]         xbar_cfg;
  logic                        xbar_valid;
  logic [N-1:0]                deq_valid;
  logic [N-1:0][AW-1:0]        deq_dst;
  logic [N-1:0]                overflow;
  logic                        sched_err;

  voq_sched_ctrl #(.N(N), .P(P), .D(D), .TMO(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .arr_valid      (arr_valid),
    .arr_dst        (arr_dst),
    .pri_req_out    (pri_req_out),
    .start          (start),
    .decision       (decision),
    .decision_ready (decision_ready),
    .xbar_cfg       (xbar_cfg),
    .xbar_valid     (xbar_valid),
    .deq_valid      (deq_valid),
    .deq_dst        (deq_dst),
    .overflow       (overflow),
    .sched_err      (sched_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 launch, 2 wait, 3 apply.
  int                  m_occ [N][N];
  int                  m_pri [N][N];
  int                  m_phase;
  int                  m_tmo;
  bit                  m_start;
  bit                  m_xv;
  logic [N-1:0][N-1:0] m_cfg;
  bit   [N-1:0]        m_dv;
  int                  m_dd [N];
  bit   [N-1:0]        m_ovf;
  bit                  m_err;

  function automatic bit legal(input logic [N-1:0][N-1:0] dm);
    int r[$];
    int c[$];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (dm[i][j]) begin
          if (m_pri[i][j] == 0) return 1'b0;
          r.push_back(i);
          c.push_back(j);
        end
    for (int a = 0; a < r.size(); a++)
      for (int b = a + 1; b < r.size(); b++)
        if (r[a] == r[b] || c[a] == c[b]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin : model
    int         any_c;
    int         pc [N][N];
    bit [N-1:0] dv_old;
    int         dd_old [N];
    bit         a, d;
    if (reset) begin
      foreach (m_occ[i, j]) begin
        m_occ[i][j] = 0;
        m_pri[i][j] = 0;
      end
      foreach (m_dd[i]) m_dd[i] = 0;
      m_phase = 0; m_tmo = 0; m_start = 0; m_xv = 0;
      m_cfg = '0; m_dv = '0; m_ovf = '0; m_err = 0;
    end else begin
      any_c = 0;
      foreach (m_occ[i, j]) begin
        if (m_occ[i][j] > 0) any_c = 1;
        pc[i][j] = (m_occ[i][j] < P - 1) ? m_occ[i][j] : P - 1;
      end
      dv_old = m_dv;
      dd_old = m_dd;
      m_xv = 0;
      m_dv = '0;
      case (m_phase)
        0: if (any_c != 0) begin
          m_phase = 1; m_start = 1; m_pri = pc;
        end
        1: begin m_phase = 2; m_tmo = 0; end
        2: if (decision_ready) begin
          m_phase = 3; m_start = 0; m_tmo = 0;
          if (legal(decision)) begin
            m_xv = 1;
            m_cfg = decision;
            for (int i = 0; i < N; i++) begin
              m_dd[i] = 0;
              for (int j = 0; j < N; j++)
                if (decision[i][j]) begin m_dv[i] = 1; m_dd[i] = j; end
            end
          end else m_err = 1;
        end else if (m_tmo == TMO - 1) begin
          m_err = 1; m_start = 0; m_phase = 0; m_tmo = 0;
        end else m_tmo++;
        default: begin
          m_phase = 0;
          foreach (m_dd[i]) m_dd[i] = 0;
        end
      endcase
      foreach (m_occ[i, j]) begin
        a = arr_valid[i] && (arr_dst[i] == j);
        d = dv_old[i] && (dd_old[i] == j);
        if (a && !d) begin
          if (m_occ[i][j] == D) m_ovf[i] = 1;
          else m_occ[i][j]++;
        end else if (d && !a) m_occ[i][j]--;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [0:N-1][0:N-1][PW-1:0] e_pri;
    logic [N-1:0][AW-1:0]        e_dd;
    if (cmp_en) begin
      foreach (m_pri[i, j]) e_pri[i][j] = PW'(m_pri[i][j]);
      foreach (m_dd[i]) e_dd[i] = AW'(m_dd[i]);
      chk("start", start, m_start);
      chk("pri_req_out", pri_req_out, e_pri);
      chk("xbar_valid", xbar_valid, m_xv);
      chk("xbar_cfg", xbar_cfg, m_cfg);
      chk("deq_valid", deq_valid, m_dv);
      chk("deq_dst", deq_dst, e_dd);
      chk("overflow", overflow, m_ovf);
      chk("sched_err", sched_err, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    for (int k = 0; k < 12; k++) begin
      if (start === 1'b1) return;
      tick();
    end
    chk("wait_start_timeout", start, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [0:N-1][0:N-1][PW-1:0] lit;
    logic [N-1:0]                used;
    bit                          seen;
    int                          st, jj, kind, tot;
    reset = 1'b1;
    arr_valid = '0;
    arr_dst = '0;
    decision = '0;
    decision_ready = 1'b0;
    repeat (4) tick();
    cmp_en = 1'b1;
    reset = 1'b0;

    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (start !== 1'b0) seen = 1;
    end
    @(negedge clk);
    chk("idle_no_start", seen, 0);
    chk("idle_pri", pri_req_out, 0);
    chk("idle_err", sched_err, 0);

    arr_valid = 4'b0001;
    arr_dst[0] = 2;
    tick();
    arr_valid = '0;
    wait_start();
    lit = '0;
    lit[0][2] = 6'd1;
    chk("single_pri02", pri_req_out[0][2], 1);
    chk("single_pri_all", pri_req_out, lit);
    repeat (3) tick();
    decision[0][2] = 1'b1;
    decision_ready = 1'b1;
    tick();
    decision_ready = 1'b0;
    decision = '0;
    @(negedge clk);
    chk("single_xv", xbar_valid, 1);
    chk("single_cfg02", xbar_cfg[0][2], 1);
    chk("single_deq_valid", deq_valid, 4'b0001);
    chk("single_deq_dst0", deq_dst[0], 2);
    chk("single_start_low", start, 0);
    tick();
    @(negedge clk);
    chk("single_xv_once", xbar_valid, 0);
    chk("single_deq_once", deq_valid, 0);
    tick();
    chk("single_occ_model", m_occ[0][2], 0);
    chk("single_back_idle", start, 0);

    arr_dst[1] = 3;
    for (int k = 0; k < 300; k++) begin
      arr_valid = 4'b0010;
      tick();
      if (k == 254) begin
        chk("sat_ovf_before", overflow[1], 0);
        chk("sat_occ_model", m_occ[1][3], 255);
      end
      if (k == 255) chk("sat_ovf_256", overflow[1], 1);
    end
    arr_valid = '0;
    @(negedge clk);
    chk("sat_pri63", pri_req_out[1][3], 63);
    chk("sat_tmo_err", sched_err, 1);
    chk("sat_in_wait", start, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    decision = '1;
    decision_ready = 1'b1;
    @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_err", sched_err, 0);
    chk("rst_ovf", overflow, 0);
    tick();
    decision_ready = 1'b0;
    decision = '0;
    @(negedge clk);
    chk("rst_no_xv", xbar_valid, 0);
    chk("rst_no_deq", deq_valid, 0);
    tot = 0;
    foreach (m_occ[i, j]) tot += m_occ[i][j];
    chk("rst_occ_model", tot, 0);

    arr_valid = 4'b0001;
    arr_dst[0] = 1;
    tick();
    arr_valid = '0;
    wait_start();
    tick();
    decision[0][1] = 1'b1;
    decision[0][2] = 1'b1;
    decision_ready = 1'b1;
    tick();
    decision_ready = 1'b0;
    decision = '0;
    @(negedge clk);
    chk("inv_row_err", sched_err, 1);
    chk("inv_row_xv", xbar_valid, 0);
    chk("inv_row_deq", deq_valid, 0);
    tick();
    chk("inv_row_occ_model", m_occ[0][1], 1);

    pulse_reset();
    arr_valid = 4'b0001;
    arr_dst[0] = 1;
    tick();
    arr_valid = '0;
    wait_start();
    tick();
    decision[1][0] = 1'b1;
    decision_ready = 1'b1;
    tick();
    decision_ready = 1'b0;
    decision = '0;
    @(negedge clk);
    chk("inv_zero_err", sched_err, 1);
    chk("inv_zero_xv", xbar_valid, 0);
    wait_start();
    tick();
    decision[0][1] = 1'b1;
    decision_ready = 1'b1;
    tick();
    decision_ready = 1'b0;
    decision = '0;
    @(negedge clk);
    chk("drain_xv", xbar_valid, 1);
    chk("drain_deq_dst0", deq_dst[0], 1);

    pulse_reset();
    arr_dst[2] = 1;
    for (int k = 0; k < 5; k++) begin
      arr_valid = 4'b0100;
      tick();
    end
    arr_valid = '0;
    decision[2][1] = 1'b1;
    decision_ready = 1'b1;
    tick();
    decision_ready = 1'b0;
    decision = '0;
    arr_valid = 4'b0100;
    @(negedge clk);
    chk("simul_deq_valid", deq_valid, 4'b0100);
    chk("simul_deq_dst2", deq_dst[2], 1);
    tick();
    arr_valid = '0;
    chk("simul_occ_model", m_occ[2][1], 5);
    wait_start();
    chk("simul_pri5", pri_req_out[2][1], 5);

    pulse_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        arr_valid[i] = ($urandom_range(0, 3) == 0);
        arr_dst[i] = AW'($urandom_range(0, N - 1));
      end
      decision_ready = 1'b0;
      decision = '0;
      if (m_phase == 2 && $urandom_range(0, 2) == 0) begin
        kind = $urandom_range(0, 9);
        if (kind < 7) begin
          used = '0;
          for (int i = 0; i < N; i++) begin
            st = $urandom_range(0, N - 1);
            for (int k = 0; k < N; k++) begin
              jj = (st + k) % N;
              if (m_pri[i][jj] > 0 && !used[jj] &&
                  $urandom_range(0, 3) != 0) begin
                decision[i][jj] = 1'b1;
                used[jj] = 1'b1;
                break;
              end
            end
          end
        end else if (kind < 9) begin
          decision = 16'($urandom);
        end
        decision_ready = 1'b1;
      end else if ($urandom_range(0, 19) == 0) begin
        decision = 16'($urandom);
        decision_ready = 1'b1;
      end
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0;
    arr_valid = '0;
    decision_ready = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
